// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

endpackage

// File: rtl/dmem_arbiter_rr_select.sv
// Two-way pick from the request vector, the last-granted pointer and the mode.
module rr_select
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            // fixed mode favours port 0; round-robin favours the port not granted last
            winner = mode ? 1'b0 : ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: arbitrate, issue one memory access, report completion.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    localparam logic FIXED_MODE = (PRIO_MODE == PRIO_FIXED);

    state_t            state;
    state_t            state_next;
    logic              last_gnt;
    logic              sel;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              pick_valid;
    logic              pick_winner;
    logic              arb_open;
    logic              in_issue;
    logic              in_resp;

    rr_select u_rr_select (
        .req    ({req1, req0}),
        .last   (last_gnt),
        .mode   (FIXED_MODE),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign arb_open = (state == IDLE) || (state == RESP);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            sel       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_next;
            if (arb_open && pick_valid) begin
                sel       <= pick_winner;
                lat_we    <= pick_winner ? we1    : we0;
                lat_addr  <= pick_winner ? addr1  : addr0;
                lat_wdata <= pick_winner ? wdata1 : wdata0;
            end
            if (state == ISSUE) begin
                last_gnt <= sel;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = pick_valid ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even before the first reset edge lands.
    assign in_issue = (state == ISSUE) && !reset;
    assign in_resp  = (state == RESP)  && !reset;

    assign gnt0  = in_issue && !sel;
    assign gnt1  = in_issue &&  sel;
    assign done0 = in_resp  && !sel;
    assign done1 = in_resp  &&  sel;

    assign rdata0 = (in_resp && !sel && !lat_we) ? mem_data_out : '0;
    assign rdata1 = (in_resp &&  sel && !lat_we) ? mem_data_out : '0;

    // Latched fields only change on entry to ISSUE, so they already hold the last access elsewhere.
    assign mem_we      = in_issue && lat_we;
    assign mem_addr    = reset ? '0 : lat_addr;
    assign mem_data_in = reset ? '0 : lat_wdata;
    assign busy        = (state != IDLE) && !reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters driven with identical stimulus.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic        gnt0, gnt1, done0, done1, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_data_in, mem_data_out;

    logic        f_gnt0, f_gnt1, f_done0, f_done1, f_mem_we, f_busy;
    logic [31:0] f_rdata0, f_rdata1, f_mem_addr, f_mem_data_in, f_mem_data_out;

    logic [31:0] mem [16];

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) u_rr (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) u_fix (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
        .rdata0(f_rdata0), .rdata1(f_rdata1),
        .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_data_in(f_mem_data_in),
        .mem_data_out(f_mem_data_out), .busy(f_busy)
    );

    assign f_mem_data_out = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory with registered read data, one cycle after the access edge.
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[3:0]] <= mem_data_in;
        mem_data_out <= mem[mem_addr[3:0]];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        step(); step();
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_gnt",    {30'd0, gnt1, gnt0},   32'd0);
        check("rst_done",   {30'd0, done1, done0}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr",   mem_addr,    32'd0);
        check("rst_wdata",  mem_data_in, 32'd0);
        check("rst_rdata",  rdata0 | rdata1, 32'd0);
        check("rst_f_busy", {31'd0, f_busy}, 32'd0);

        // single write on port 0, then read back on port 1
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        step();
        check("wr_gnt0",   {31'd0, gnt0},   32'd1);
        check("wr_gnt1",   {31'd0, gnt1},   32'd0);
        check("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr_addr",   mem_addr,    32'h10);
        check("wr_data",   mem_data_in, 32'hDEADBEEF);
        check("wr_busy",   {31'd0, busy},   32'd1);
        req0 = 1'b0; we0 = 1'b0;
        step();
        check("wr_done0",    {31'd0, done0},  32'd1);
        check("wr_done1",    {31'd0, done1},  32'd0);
        check("wr_we_off",   {31'd0, mem_we}, 32'd0);
        check("wr_addr_hold", mem_addr, 32'h10);
        check("wr_rdata0",   rdata0, 32'd0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10;
        step();
        check("rd_gnt1",   {31'd0, gnt1},   32'd1);
        check("rd_gnt0",   {31'd0, gnt0},   32'd0);
        check("rd_mem_we", {31'd0, mem_we}, 32'd0);
        check("rd_addr",   mem_addr, 32'h10);
        req1 = 1'b0;
        step();
        check("rd_done1",  {31'd0, done1}, 32'd1);
        check("rd_rdata1", rdata1, 32'hDEADBEEF);
        check("rd_rdata0", rdata0, 32'd0);
        step();
        check("rd_idle_busy",  {31'd0, busy}, 32'd0);
        check("rd_idle_done1", {31'd0, done1}, 32'd0);
        check("rd_idle_rdata", rdata1, 32'd0);

        // continuous tie: round-robin alternates 0,1,0,1; fixed always grants 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h1; wdata0 = 32'hAAAA0001;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h2; wdata1 = 32'hBBBB0002;
        for (int i = 0; i < 4; i++) begin
            step();
            check("tie_gnt",     {30'd0, gnt1, gnt0},     (i % 2 == 0) ? 32'd1 : 32'd2);
            check("tie_fix_gnt", {30'd0, f_gnt1, f_gnt0}, 32'd1);
            step();
            check("tie_gap_gnt", {30'd0, gnt1, gnt0},   32'd0);
            check("tie_done",    {30'd0, done1, done0}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        req0 = 1'b0;
        step();
        check("fix_gnt1_after_drop", {30'd0, f_gnt1, f_gnt0}, 32'd2);
        check("rr_single_gnt1",      {30'd0, gnt1, gnt0},     32'd2);
        req1 = 1'b0;
        step();
        check("fix_done1", {31'd0, f_done1}, 32'd1);
        step();
        check("tie_idle", {30'd0, f_busy, busy}, 32'd0);

        // reset during port 1's write ISSUE cycle
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h3; wdata1 = 32'hCCCC0003;
        step();
        check("rst_iss_gnt1", {31'd0, gnt1}, 32'd1);
        reset = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
        #1;
        check("rst_iss_gnt_held", {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_iss_we_held",  {31'd0, mem_we},     32'd0);
        step();
        check("rst_iss_done", {30'd0, done1, done0}, 32'd0);
        check("rst_iss_we",   {31'd0, mem_we}, 32'd0);
        check("rst_iss_busy", {31'd0, busy},   32'd0);
        check("rst_iss_addr", mem_addr, 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_gnt",     {30'd0, gnt1, gnt0},     32'd1);
        check("post_rst_fix_gnt", {30'd0, f_gnt1, f_gnt0}, 32'd1);
        req0 = 1'b0;
        step();
        check("post_rst_done0", {31'd0, done0}, 32'd1);
        step();
        check("post_rst_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        check("post_rst_wr",   mem_data_in, 32'hCCCC0003);
        req1 = 1'b0;
        step();
        check("post_rst_done1", {31'd0, done1}, 32'd1);
        step();

        // port 1 drops req and scrambles its fields right after being latched
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'hFFFFFFF5; wdata1 = 32'h12345678;
        step();
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        #1;
        check("drop_gnt1",   {31'd0, gnt1},   32'd1);
        check("drop_mem_we", {31'd0, mem_we}, 32'd1);
        check("drop_addr",   mem_addr,    32'hFFFFFFF5);
        check("drop_data",   mem_data_in, 32'h12345678);
        step();
        check("drop_done1", {31'd0, done1}, 32'd1);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'hFFFFFFF5;
        step();
        check("rb_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        step();
        check("rb_done0",  {30'd0, done1, done0}, 32'd1);
        check("rb_rdata0", rdata0, 32'h12345678);
        check("rb_rdata1", rdata1, 32'd0);
        step();
        check("end_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be `ADDR_W`, default 32, address width.
REQ-002 Parameters SHALL include `DATA_W`, default 32, data width.
REQ-003 Parameters SHALL include `PRIO_MODE`, default 0, where 0 selects round-robin and 1 selects fixed priority with port 0 winning.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port `clock`: input, 1 bit, sole clock; all state changes on its rising edge.
REQ-006 Port `reset`: input, 1 bit, synchronous active-high reset.
REQ-007 Ports `req0` / `req1`: input, 1 bit each, access request; held high until the matching gnt.
REQ-008 Ports `we0` / `we1`: input, 1 bit each, 1 = write, 0 = read; stable while req is high.
REQ-009 Ports `addr0` / `addr1`: input, ADDR_W each, word address; stable while req is high.
REQ-010 Ports `wdata0` / `wdata1`: input, DATA_W each, write data; stable while req is high.
REQ-011 Ports `gnt0` / `gnt1`: output, 1 bit each, one-cycle pulse marking the request as accepted.
REQ-012 Ports `done0` / `done1`: output, 1 bit each, one-cycle completion pulse for both reads and writes.
REQ-013 Ports `rdata0` / `rdata1`: output, DATA_W each, read data, valid only while the matching done is high after a read.
REQ-014 Port `mem_we`: output, 1 bit, memory write enable.
REQ-015 Port `mem_addr`: output, ADDR_W, memory address.
REQ-016 Port `mem_data_in`: output, DATA_W, memory write data.
REQ-017 Port `mem_data_out`: input, DATA_W, memory read data, registered by the memory one cycle after the read edge.
REQ-018 Port `busy`: output, 1 bit, high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and RESP.
  - IDLE -> ISSUE when any req is high.
  - ISSUE -> RESP unconditionally.
  - RESP -> ISSUE when any req is high, else RESP -> IDLE.
REQ-020 Arbitration SHALL happen only in IDLE or RESP cycles; the winner's we, addr and wdata SHALL be latched at that edge.
REQ-021 In round-robin mode, when both requests are high, the port not granted last SHALL win; the last-granted pointer SHALL reset to port 1, so port 0 wins the first tie.
REQ-022 In fixed-priority mode, port 0 SHALL win every tie.
REQ-023 A single pending request SHALL win regardless of mode or pointer.
REQ-024 In ISSUE the block SHALL:
  - drive mem_addr, mem_we and mem_data_in from the latched request;
  - pulse gnt for the winner only;
  - update the pointer to the winner.
REQ-025 Outside ISSUE, mem_we SHALL be 0; mem_addr and mem_data_in SHALL hold their last values.
REQ-026 In RESP the block SHALL pulse done for the winner; for a read, rdata of that port SHALL equal mem_data_out; rdata SHALL be 0 otherwise.
REQ-027 Latency SHALL be: request seen at arbitration edge T, gnt and memory access in cycle T+1, done in cycle T+2; back-to-back accesses every 2 cycles.
REQ-028 A requester SHALL only assert a new req from the cycle after its gnt; a req seen during RESP SHALL be arbitrated in that same cycle.
REQ-029 A req dropped after latching and before gnt SHALL NOT abort the transaction; it completes with the latched fields.
REQ-030 gnt0 and gnt1 SHALL never be high together, nor shall done0 and done1.
REQ-031 Address and data SHALL pass through unmodified; no range check is made, and the full ADDR_W space is legal.

Reset
REQ-032 While reset is high, the FSM SHALL be IDLE and all of gnt, done, rdata, mem_we and busy SHALL be 0.
REQ-033 While reset is high, mem_addr, mem_data_in and the latched fields SHALL be 0, and the pointer SHALL be 1.
REQ-034 On reset mid-transaction, the in-flight access SHALL be discarded with no gnt or done; requesters re-request after reset.
REQ-035 No request SHALL be arbitrated in a cycle where reset is high.

Structure
REQ-036 Package `dmem_arb_pkg` SHALL hold the state enum (IDLE, ISSUE, RESP) and the constants PRIO_RR = 0 and PRIO_FIXED = 1.
REQ-037 Sub-module `rr_select` SHALL implement the 2-way priority pick from the req vector, pointer and mode; all other logic stays in `dmem_arbiter`.

Verification
REQ-038 Single write: req0 = 1, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF from IDLE.
  - Expected: gnt0 at T+1 with mem_we = 1 and mem_addr = 0x10; done0 at T+2.
  - Follow with a read of 0x10 on port 1: done1 with rdata1 = 0xDEADBEEF.
REQ-039 Tie under round-robin: req0 and req1 held high continuously.
  - Expected grant order: 0, 1, 0, 1; a gnt every 2 cycles; gnt signals never overlap.
REQ-040 Fixed mode: PRIO_MODE = 1 with both req held high for 3 grants.
  - Expected: three gnt0 pulses and no gnt1; after req0 drops, gnt1 follows within 2 cycles.
REQ-041 Reset in ISSUE: assert reset during port 1's ISSUE cycle.
  - Expected: no done1, mem_we = 0 in the next cycle, busy = 0.
  - After release with both req high, port 0 is granted first.
REQ-042 Drop after latch: req1 falls on the cycle after the arbitration edge.
  - Expected: gnt1 and done1 still occur, with the latched addr and data.
